sad_ctrl: RTL and testbench

- FSM controller that sequences the SAD datapath: clears the index counter and sum register, then loops over all 256 A/B elements.
- Each element gets one compare step, an optional memory read-latency wait and one accumulate step. At the end the final sum is loaded into the SAD register.
- Presents a go/busy/done handshake to the host and supports abort and SAD-register clear.
- Sits between the host and the datapath; drives every datapath control input and consumes i_lt_256.

---
 rtl/sad_pkg.sv | 18 +
 rtl/sad_ctrl.sv | 92 +++++++++
 tb/tb_sad_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD controller and its datapath.
// The state encoding is common to the controller and any monitors.
package sad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    WAIT,
    ACC,
    STORE,
    DONE
  } sad_state_t;

  localparam int N_ELEMS    = 256;
  localparam int RD_LAT_MAX = 7;

endpackage

// File: rtl/sad_ctrl.sv
// Moore sequencer for the SAD datapath: clear, per-element compare/wait/accumulate,
// then store the sum.
// Only sadreg_clr looks at an input, and only in IDLE.
module sad_ctrl
  import sad_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic abort,
  input  logic sad_clr_req,
  input  logic i_lt_256,
  output logic i_inc,
  output logic i_clr,
  output logic sum_ld,
  output logic sum_clr,
  output logic sadreg_ld,
  output logic sadreg_clr,
  output logic busy,
  output logic done
);

  // WAIT runs from RD_LAT-1 down to 0, giving exactly RD_LAT wait cycles.
  localparam logic [2:0] WAIT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  sad_state_t state;
  sad_state_t state_next;
  logic [2:0] wait_cnt;
  logic [2:0] wait_cnt_next;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (!abort && go) state_next = INIT;
      end
      INIT: begin
        state_next = abort ? IDLE : CHECK;
      end
      CHECK: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!i_lt_256) begin
          state_next = STORE;
        end else if (RD_LAT > 0) begin
          state_next    = WAIT;
          wait_cnt_next = WAIT_LOAD;
        end else begin
          state_next = ACC;
        end
      end
      WAIT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (wait_cnt == 3'd0) begin
          state_next = ACC;
        end else begin
          wait_cnt_next = wait_cnt - 3'd1;
        end
      end
      ACC: begin
        state_next = abort ? IDLE : CHECK;
      end
      STORE: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  assign i_clr      = (state == INIT);
  assign sum_clr    = (state == INIT);
  assign sum_ld     = (state == ACC);
  assign i_inc      = (state == ACC);
  assign sadreg_ld  = (state == STORE);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);
  assign sadreg_clr = (state == IDLE) && sad_clr_req;

endmodule

// File: tb/tb_sad_ctrl.sv
// Bench for sad_ctrl: two controllers (RD_LAT=0 and RD_LAT=2) each driving a
// behavioural datapath; results are compared with a plain-arithmetic reference.
module tb_sad_ctrl;

  logic clk;
  logic rst;
  logic [1:0] go;
  logic [1:0] abort;
  logic [1:0] clr_req;
  logic [1:0] i_lt;
  logic [1:0] i_inc;
  logic [1:0] i_clr;
  logic [1:0] sum_ld;
  logic [1:0] sum_clr;
  logic [1:0] sadreg_ld;
  logic [1:0] sadreg_clr;
  logic [1:0] busy;
  logic [1:0] done;

  int mem_a [256];
  int mem_b [256];
  int idx   [2];
  int sum_m [2];
  int sad_m [2];

  int cyc;
  int sumld_cnt [2];
  int last_sumld [2];
  int spacing_bad [2];
  int sadld_cnt [2];
  int sadld_cyc [2];
  int done_cnt [2];
  int done_cyc [2];
  int busy_cnt [2];
  int mutex_bad [2];

  int errors;
  int checks;
  int c0, bd, bs, bl, bb, bsp;

  sad_ctrl #(.RD_LAT(0)) u_ctrl0 (
    .clk(clk), .rst(rst), .go(go[0]), .abort(abort[0]), .sad_clr_req(clr_req[0]),
    .i_lt_256(i_lt[0]), .i_inc(i_inc[0]), .i_clr(i_clr[0]), .sum_ld(sum_ld[0]),
    .sum_clr(sum_clr[0]), .sadreg_ld(sadreg_ld[0]), .sadreg_clr(sadreg_clr[0]),
    .busy(busy[0]), .done(done[0])
  );

  sad_ctrl #(.RD_LAT(2)) u_ctrl2 (
    .clk(clk), .rst(rst), .go(go[1]), .abort(abort[1]), .sad_clr_req(clr_req[1]),
    .i_lt_256(i_lt[1]), .i_inc(i_inc[1]), .i_clr(i_clr[1]), .sum_ld(sum_ld[1]),
    .sum_clr(sum_clr[1]), .sadreg_ld(sadreg_ld[1]), .sadreg_clr(sadreg_clr[1]),
    .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign i_lt = {idx[1] < 256, idx[0] < 256};

  // Behavioural datapath: index counter, running sum and SAD register.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (i_clr[u]) idx[u] <= 0;
      else if (i_inc[u]) idx[u] <= idx[u] + 1;
      if (sum_clr[u]) sum_m[u] <= 0;
      else if (sum_ld[u] && idx[u] < 256)
        sum_m[u] <= sum_m[u] + ((mem_a[idx[u]] > mem_b[idx[u]]) ?
                    mem_a[idx[u]] - mem_b[idx[u]] : mem_b[idx[u]] - mem_a[idx[u]]);
      if (sadreg_clr[u]) sad_m[u] <= 0;
      else if (sadreg_ld[u]) sad_m[u] <= sum_m[u];
    end
  end

  // Event recorder sampled on the falling edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (i_clr[u]) last_sumld[u] <= -1;
      if (sum_ld[u]) begin
        sumld_cnt[u] <= sumld_cnt[u] + 1;
        if (last_sumld[u] >= 0 && cyc - last_sumld[u] != perElem(u))
          spacing_bad[u] <= spacing_bad[u] + 1;
        last_sumld[u] <= cyc;
      end
      if (sadreg_ld[u]) begin
        sadld_cnt[u] <= sadld_cnt[u] + 1;
        sadld_cyc[u] <= cyc;
      end
      if (done[u]) begin
        done_cnt[u] <= done_cnt[u] + 1;
        done_cyc[u] <= cyc;
      end
      if (busy[u]) busy_cnt[u] <= busy_cnt[u] + 1;
      if ((i_clr[u] && i_inc[u]) || (sum_clr[u] && sum_ld[u]) || (sadreg_clr[u] && sadreg_ld[u]))
        mutex_bad[u] <= mutex_bad[u] + 1;
    end
  end

  function automatic int perElem(int u);
    return (u == 0) ? 2 : 4;
  endfunction

  function automatic int refSad();
    int s = 0;
    for (int k = 0; k < 256; k++)
      s += (mem_a[k] > mem_b[k]) ? mem_a[k] - mem_b[k] : mem_b[k] - mem_a[k];
    return s;
  endfunction

  function automatic int outs(int u);
    return int'({i_inc[u], i_clr[u], sum_ld[u], sum_clr[u], sadreg_ld[u], sadreg_clr[u], busy[u], done[u]});
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, int observed, int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic randomizeMem();
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = int'($urandom_range(255, 0));
      mem_b[k] = int'($urandom_range(255, 0));
    end
  endtask

  task automatic snap(int u);
    c0  = cyc;
    bd  = done_cnt[u];
    bs  = sumld_cnt[u];
    bl  = sadld_cnt[u];
    bb  = busy_cnt[u];
    bsp = spacing_bad[u];
  endtask

  task automatic applyStimulus(int u);
    snap(u);
    go[u] = 1'b1;
    step();
    go[u] = 1'b0;
  endtask

  task automatic waitDone(int u, int bound);
    int n = 0;
    while (done_cnt[u] == bd && n < bound) begin
      step();
      n++;
    end
    checkOutput("done_seen", done_cnt[u] - bd, 1);
  endtask

  task automatic checkRun(int u, int exp_sad);
    int total;
    total = 4 + 256 * perElem(u);
    waitDone(u, 3000);
    checkOutput("done_cycle", done_cyc[u] - c0, total);
    checkOutput("sadld_count", sadld_cnt[u] - bl, 1);
    checkOutput("sadld_cycle", sadld_cyc[u] - c0, total - 1);
    checkOutput("sumld_count", sumld_cnt[u] - bs, 256);
    checkOutput("sumld_spacing", spacing_bad[u] - bsp, 0);
    checkOutput("busy_cycles", busy_cnt[u] - bb, total);
    checkOutput("sad_value", sad_m[u], exp_sad);
    step();
    checkOutput("idle_after_done", int'(busy[u]), 0);
  endtask

  initial begin
    int saved;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    go = '0;
    abort = '0;
    clr_req = '0;
    for (int u = 0; u < 2; u++) last_sumld[u] = -1;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_outs_lat0", outs(0), 0);
    checkOutput("reset_outs_lat2", outs(1), 0);

    // Full runs with random data at both latencies; stray go mid-run is ignored.
    randomizeMem();
    applyStimulus(1);
    checkRun(1, refSad());
    randomizeMem();
    applyStimulus(0);
    while (cyc < c0 + 100) step();
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    checkRun(0, refSad());

    // Known pattern: A[k]=k, B[k]=255-k.
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = k;
      mem_b[k] = 255 - k;
    end
    applyStimulus(1);
    checkRun(1, 32768);

    // Abort mid-run keeps the previous SAD; a fresh run then completes.
    randomizeMem();
    applyStimulus(1);
    while (cyc < c0 + 300) step();
    abort[1] = 1'b1;
    step();
    abort[1] = 1'b0;
    checkOutput("abort_idle", int'(busy[1]), 0);
    checkOutput("abort_no_sadld", sadld_cnt[1] - bl, 0);
    checkOutput("abort_sad_kept", sad_m[1], 32768);
    applyStimulus(1);
    checkRun(1, refSad());

    // Reset while in WAIT.
    saved = sad_m[1];
    applyStimulus(1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_wait_outs", outs(1), 0);
    checkOutput("rst_wait_sad_kept", sad_m[1], saved);

    // go and abort together in IDLE stay in IDLE.
    go[1] = 1'b1;
    abort[1] = 1'b1;
    step();
    go[1] = 1'b0;
    abort[1] = 1'b0;
    checkOutput("go_abort_busy", int'(busy[1]), 0);
    checkOutput("go_abort_iclr", int'(i_clr[1]), 0);

    // Clear request with go: clear this cycle, INIT next; clear ignored while busy.
    randomizeMem();
    snap(1);
    clr_req[1] = 1'b1;
    go[1] = 1'b1;
    #1;
    checkOutput("clr_go_sadreg_clr", int'(sadreg_clr[1]), 1);
    step();
    go[1] = 1'b0;
    checkOutput("clr_go_init", int'(i_clr[1]), 1);
    checkOutput("clr_go_sad_zero", sad_m[1], 0);
    while (cyc < c0 + 50) step();
    checkOutput("clr_busy_ignored", int'(sadreg_clr[1]), 0);
    clr_req[1] = 1'b0;
    checkRun(1, refSad());

    // go held high gives back-to-back runs with one IDLE cycle between.
    randomizeMem();
    snap(0);
    go[0] = 1'b1;
    waitDone(0, 1000);
    step();
    checkOutput("b2b_idle_gap", int'(busy[0]), 0);
    step();
    checkOutput("b2b_next_init", int'(i_clr[0]), 1);
    go[0] = 1'b0;
    bd = done_cnt[0];
    waitDone(0, 1000);
    checkOutput("b2b_sad", sad_m[0], refSad());

    checkOutput("mutex_lat0", mutex_bad[0], 0);
    checkOutput("mutex_lat2", mutex_bad[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
